// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN frame-scan controller: scan FSM states,
// default frame geometry, pixel index width and bounding-box reset constants.
package cnn_pkg;

    localparam int unsigned ImgWDefault = 64;
    localparam int unsigned ImgHDefault = 64;
    localparam int unsigned IdxW        = 7;

    typedef logic [IdxW-1:0] idx_t;

    // Min registers start high and max registers start low so the first hit sets both.
    localparam idx_t BboxMinRst = 7'd127;
    localparam idx_t BboxMaxRst = 7'd0;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } scan_state_e;

endpackage

// File: rtl/cnn_scan_controller_if.sv
// Request/response and status bundle between the scan controller and its neighbours.
// The master modport is the scan controller; the slave modport is the surrounding logic.
interface cnn_scan_controller_if
    import cnn_pkg::*;
#(
    parameter int unsigned CNT_W = 12
);

    logic             frame_go;
    logic             busy;
    idx_t             row;
    idx_t             col;
    logic             start;
    logic             cnn_valid;
    logic             cnn_detect;
    logic [CNT_W-1:0] det_count;
    idx_t             bb_rmin;
    idx_t             bb_rmax;
    idx_t             bb_cmin;
    idx_t             bb_cmax;
    logic             bb_valid;
    logic             done;
    logic             err;

    modport master (
        input  frame_go,
        input  cnn_valid,
        input  cnn_detect,
        output busy,
        output row,
        output col,
        output start,
        output det_count,
        output bb_rmin,
        output bb_rmax,
        output bb_cmin,
        output bb_cmax,
        output bb_valid,
        output done,
        output err
    );

    modport slave (
        output frame_go,
        output cnn_valid,
        output cnn_detect,
        input  busy,
        input  row,
        input  col,
        input  start,
        input  det_count,
        input  bb_rmin,
        input  bb_rmax,
        input  bb_cmin,
        input  bb_cmax,
        input  bb_valid,
        input  done,
        input  err
    );

endinterface

// File: rtl/cnn_bbox_tracker.sv
// Bounding-box tracker: running min/max of detected row/col plus a seen-any flag.
// Only compiled and used when CNN_SCAN_BBOX_EN is defined.
`ifdef CNN_SCAN_BBOX_EN
module cnn_bbox_tracker
    import cnn_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic upd_i,
    input  idx_t row_i,
    input  idx_t col_i,
    output idx_t rmin_o,
    output idx_t rmax_o,
    output idx_t cmin_o,
    output idx_t cmax_o,
    output logic valid_o
);

    idx_t rmin_q, rmin_d;
    idx_t rmax_q, rmax_d;
    idx_t cmin_q, cmin_d;
    idx_t cmax_q, cmax_d;
    logic valid_q, valid_d;

    always_comb begin
        rmin_d  = rmin_q;
        rmax_d  = rmax_q;
        cmin_d  = cmin_q;
        cmax_d  = cmax_q;
        valid_d = valid_q;
        if (clear_i) begin
            rmin_d  = BboxMinRst;
            rmax_d  = BboxMaxRst;
            cmin_d  = BboxMinRst;
            cmax_d  = BboxMaxRst;
            valid_d = 1'b0;
        end else if (upd_i) begin
            if (row_i < rmin_q) rmin_d = row_i;
            if (row_i > rmax_q) rmax_d = row_i;
            if (col_i < cmin_q) cmin_d = col_i;
            if (col_i > cmax_q) cmax_d = col_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rmin_q  <= BboxMinRst;
            rmax_q  <= BboxMaxRst;
            cmin_q  <= BboxMinRst;
            cmax_q  <= BboxMaxRst;
            valid_q <= 1'b0;
        end else begin
            rmin_q  <= rmin_d;
            rmax_q  <= rmax_d;
            cmin_q  <= cmin_d;
            cmax_q  <= cmax_d;
            valid_q <= valid_d;
        end
    end

    assign rmin_o  = rmin_q;
    assign rmax_o  = rmax_q;
    assign cmin_o  = cmin_q;
    assign cmax_o  = cmax_q;
    assign valid_o = valid_q;

endmodule
`endif

// File: rtl/cnn_scan_controller.sv
// Frame-scan initiator: walks interior pixels row-major, one request per pixel, and
// accumulates detections. Define CNN_SCAN_BBOX_EN to build the bounding-box tracker.
module cnn_scan_controller
    import cnn_pkg::*;
#(
    parameter int unsigned IMG_W   = ImgWDefault,
    parameter int unsigned IMG_H   = ImgHDefault,
    parameter int unsigned CNT_W   = 12,
    parameter int unsigned TIMEOUT = 15
) (
    input logic                   clk,
    input logic                   rst_n,
    cnn_scan_controller_if.master bus
);

    // wait_q counts 0..TIMEOUT-1, so the frame aborts after TIMEOUT silent WAIT cycles.
    localparam int unsigned WaitW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);
    localparam idx_t RowLast = idx_t'(IMG_H - 2);
    localparam idx_t ColLast = idx_t'(IMG_W - 2);

    scan_state_e      state_q, state_d;
    idx_t             row_q, row_d;
    idx_t             col_q, col_d;
    logic             start_q, start_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WaitW-1:0] wait_q, wait_d;

    logic accept;
    logic hit;
    logic last_pix;

    // Responses only count in WAIT; stray valids elsewhere are dropped.
    assign accept   = (state_q == StIdle) && bus.frame_go;
    assign hit      = (state_q == StWait) && bus.cnn_valid && bus.cnn_detect;
    assign last_pix = (row_q == RowLast) && (col_q == ColLast);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        busy_d  = busy_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StIssue;
                    row_d   = idx_t'(1);
                    col_d   = idx_t'(1);
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            StIssue: begin
                state_d = StWait;
                wait_d  = '0;
            end
            StWait: begin
                if (bus.cnn_valid) begin
                    if (hit && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
                    if (last_pix) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StIssue;
                        start_d = 1'b1;
                        if (col_q == ColLast) begin
                            col_d = idx_t'(1);
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end else if (wait_q == WaitLast) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            row_q   <= '0;
            col_q   <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            start_q <= start_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
        end
    end

    assign bus.row       = row_q;
    assign bus.col       = col_q;
    assign bus.start     = start_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
    assign bus.det_count = cnt_q;

`ifdef CNN_SCAN_BBOX_EN
    cnn_bbox_tracker u_bbox (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (accept),
        .upd_i   (hit),
        .row_i   (row_q),
        .col_i   (col_q),
        .rmin_o  (bus.bb_rmin),
        .rmax_o  (bus.bb_rmax),
        .cmin_o  (bus.bb_cmin),
        .cmax_o  (bus.bb_cmax),
        .valid_o (bus.bb_valid)
    );
`else
    assign bus.bb_rmin  = BboxMinRst;
    assign bus.bb_rmax  = BboxMaxRst;
    assign bus.bb_cmin  = BboxMinRst;
    assign bus.bb_cmax  = BboxMaxRst;
    assign bus.bb_valid = 1'b0;
`endif

    a_start_single: assert property (@(posedge clk) disable iff (!rst_n) start_q |=> !start_q);
    a_done_single:  assert property (@(posedge clk) disable iff (!rst_n) done_q |=> !done_q);
    a_start_issue:  assert property (@(posedge clk) disable iff (!rst_n)
                                     start_q |-> (state_q == StIssue));

endmodule

// File: tb/tb_cnn_scan_controller.sv
// Scoreboard bench for cnn_scan_controller: a frame-level reference model queues expected
// requests and per-frame results; a monitor pops and compares on every start/done.
module tb_cnn_scan_controller;

    localparam int unsigned IMG_W   = 64;
    localparam int unsigned IMG_H   = 64;
    localparam int unsigned CNT_W   = 12;
    localparam int unsigned TIMEOUT = 15;
    localparam int          NPIX    = (IMG_W - 2) * (IMG_H - 2);
`ifdef CNN_SCAN_BBOX_EN
    localparam bit BboxEn = 1'b1;
`else
    localparam bit BboxEn = 1'b0;
`endif

    typedef struct {
        int r;
        int c;
    } req_t;

    typedef struct {
        int cnt;
        int rmin;
        int rmax;
        int cmin;
        int cmax;
        int bbv;
        int err;
        int lat;
    } res_t;

    req_t req_q[$];
    res_t res_q[$];
    req_t mon_req;
    res_t mon_res;

    int n_tests = 0;
    int n_fail  = 0;
    int n_start = 0;
    int n_done  = 0;
    int cyc     = 0;
    int go_cyc  = 0;
    bit prev_start = 1'b0;
    bit acc_noresp = 1'b0;
    bit stray_en   = 1'b0;
    bit pat [0:63][0:63];

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cnn_scan_controller_if #(.CNT_W(CNT_W)) bus ();

    cnn_scan_controller #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Accelerator: answers a start seen this cycle with valid on the next cycle.
    initial begin
        logic       s;
        logic [6:0] r;
        logic [6:0] c;
        bus.cnn_valid  = 1'b0;
        bus.cnn_detect = 1'b0;
        forever begin
            @(negedge clk);
            s = bus.start;
            r = bus.row;
            c = bus.col;
            @(posedge clk);
            #1;
            if (s && !acc_noresp) begin
                bus.cnn_valid  = 1'b1;
                bus.cnn_detect = pat[r[5:0]][c[5:0]];
            end else if (stray_en && ($urandom_range(0, 3) == 0)) begin
                bus.cnn_valid  = 1'b1;
                bus.cnn_detect = 1'b1;
            end else begin
                bus.cnn_valid  = 1'b0;
                bus.cnn_detect = ($urandom_range(0, 1) == 1);
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (bus.start) begin
            n_start++;
            chk("start_back_to_back", int'(prev_start), 0);
            if (req_q.size() == 0) begin
                chk("pending_requests", req_q.size(), 1);
            end else begin
                mon_req = req_q.pop_front();
                chk("req_row", int'(bus.row), mon_req.r);
                chk("req_col", int'(bus.col), mon_req.c);
            end
        end
        prev_start = bus.start;
        if (bus.done) begin
            n_done++;
            if (res_q.size() == 0) begin
                chk("pending_results", res_q.size(), 1);
            end else begin
                mon_res = res_q.pop_front();
                chk("det_count", int'(bus.det_count), mon_res.cnt);
                chk("bb_rmin", int'(bus.bb_rmin), mon_res.rmin);
                chk("bb_rmax", int'(bus.bb_rmax), mon_res.rmax);
                chk("bb_cmin", int'(bus.bb_cmin), mon_res.cmin);
                chk("bb_cmax", int'(bus.bb_cmax), mon_res.cmax);
                chk("bb_valid", int'(bus.bb_valid), mon_res.bbv);
                chk("err", int'(bus.err), mon_res.err);
                chk("done_latency", cyc - go_cyc, mon_res.lat);
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_start"}, int'(bus.start), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_err"}, int'(bus.err), 0);
        chk({tag, "_bb_valid"}, int'(bus.bb_valid), 0);
        chk({tag, "_row"}, int'(bus.row), 0);
        chk({tag, "_col"}, int'(bus.col), 0);
        chk({tag, "_det_count"}, int'(bus.det_count), 0);
        chk({tag, "_bb_rmin"}, int'(bus.bb_rmin), 127);
        chk({tag, "_bb_rmax"}, int'(bus.bb_rmax), 0);
        chk({tag, "_bb_cmin"}, int'(bus.bb_cmin), 127);
        chk({tag, "_bb_cmax"}, int'(bus.bb_cmax), 0);
    endtask

    task automatic fill_pattern(input int one_in);
        for (int r = 0; r < 64; r++) begin
            for (int c = 0; c < 64; c++) begin
                pat[r][c] = (one_in > 0) && ($urandom_range(1, one_in) == 1);
            end
        end
    endtask

    // Reference model: full raster scan over the interior, result derived from the pattern.
    task automatic expect_frame(input int max_req, input bit want_result);
        res_t e;
        int   cnt  = 0;
        int   rmin = 127;
        int   rmax = 0;
        int   cmin = 127;
        int   cmax = 0;
        int   n    = 0;
        for (int r = 1; r <= IMG_H - 2; r++) begin
            for (int c = 1; c <= IMG_W - 2; c++) begin
                if (n < max_req) req_q.push_back('{r: r, c: c});
                n++;
                if (pat[6'(r)][6'(c)]) begin
                    if (cnt < (1 << CNT_W) - 1) cnt++;
                    if (r < rmin) rmin = r;
                    if (r > rmax) rmax = r;
                    if (c < cmin) cmin = c;
                    if (c > cmax) cmax = c;
                end
            end
        end
        e.cnt  = cnt;
        e.rmin = BboxEn ? rmin : 127;
        e.rmax = BboxEn ? rmax : 0;
        e.cmin = BboxEn ? cmin : 127;
        e.cmax = BboxEn ? cmax : 0;
        e.bbv  = (BboxEn && cnt > 0) ? 1 : 0;
        e.err  = 0;
        e.lat  = 1 + 2 * NPIX;
        if (want_result) res_q.push_back(e);
    endtask

    task automatic pulse_go();
        @(posedge clk);
        #1;
        bus.frame_go = 1'b1;
        go_cyc = cyc;
        @(posedge clk);
        #1;
        bus.frame_go = 1'b0;
    endtask

    task automatic run_frame(input bit pulse_en);
        int d0 = n_done;
        int budget = 0;
        pulse_go();
        chk("busy_after_go", int'(bus.busy), 1);
        while (budget < 2 * NPIX + 100) begin
            @(posedge clk);
            #1;
            budget++;
            if (n_done != d0) break;
            bus.frame_go = pulse_en && ($urandom_range(0, 299) == 0);
        end
        bus.frame_go = 1'b0;
        chk("frame_done_seen", n_done - d0, 1);
        chk("busy_after_done", int'(bus.busy), 0);
        chk("leftover_requests", req_q.size(), 0);
        req_q.delete();
        res_q.delete();
        repeat (3) @(posedge clk);
    endtask

    initial begin
        res_t t;
        int   base;
        int   d0;
        int   budget;
        rst_n        = 1'b0;
        bus.frame_go = 1'b0;
        #3;
        check_reset("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // No detections anywhere.
        fill_pattern(0);
        expect_frame(NPIX, 1'b1);
        run_frame(1'b0);

        // Two isolated detections, stray valids between requests.
        fill_pattern(0);
        pat[5][10] = 1'b1;
        pat[40][3] = 1'b1;
        stray_en   = 1'b1;
        expect_frame(NPIX, 1'b1);
        run_frame(1'b0);

        // Every pixel detects.
        for (int r = 0; r < 64; r++) for (int c = 0; c < 64; c++) pat[r][c] = 1'b1;
        expect_frame(NPIX, 1'b1);
        run_frame(1'b0);

        // Accelerator never answers: abort after TIMEOUT silent cycles.
        stray_en   = 1'b0;
        acc_noresp = 1'b1;
        req_q.push_back('{r: 1, c: 1});
        t = '{cnt: 0, rmin: 127, rmax: 0, cmin: 127, cmax: 0, bbv: 0, err: 1, lat: TIMEOUT + 2};
        res_q.push_back(t);
        run_frame(1'b0);
        chk("err_sticky", int'(bus.err), 1);
        acc_noresp = 1'b0;

        // Sparse random frame with ignored mid-scan frame_go pulses; err must clear.
        fill_pattern(64);
        stray_en = 1'b1;
        expect_frame(NPIX, 1'b1);
        run_frame(1'b1);
        chk("err_cleared", int'(bus.err), 0);

        // Reset asserted while pixel 100 is outstanding.
        fill_pattern(8);
        expect_frame(100, 1'b0);
        base = n_start;
        d0   = n_done;
        pulse_go();
        budget = 0;
        while ((n_start - base < 100) && (budget < 1000)) begin
            @(posedge clk);
            #1;
            budget++;
            bus.frame_go = ($urandom_range(0, 49) == 0);
        end
        bus.frame_go = 1'b0;
        chk("reached_pixel_100", n_start - base, 100);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset("mid_reset");
        chk("requests_before_reset", req_q.size(), 0);
        req_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("no_done_after_reset", n_done - d0, 0);
        check_reset("post_reset_idle");

        // Dense random frame after recovery.
        fill_pattern(2);
        expect_frame(NPIX, 1'b1);
        run_frame(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got time limit at %0d starts, expected bench completion", n_start);
        $fatal(1, "watchdog");
    end

endmodule
